single_frame_loader: RTL and testbench

//  Write-side counterpart of single_frame_store. Software writes a FRAME_WIDTH-bit frame as 32-bit AXI register words into a

---
 rtl/pixel_buffer_pkg.sv | 22 ++
 rtl/single_frame_loader_if.sv | 33 +++
 rtl/single_frame_loader_rise_edge_detect.sv | 20 ++
 rtl/single_frame_loader.sv | 144 ++++++++++++++
 tb/tb_single_frame_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_buffer_pkg.sv
// Shared definitions for the frame store/loader register blocks.
// Holds the AXI word width, the frame-to-word sizing helper and the bit
// positions of the status readback word, so that loader and store decode
// their status words the same way.
package pixel_buffer_pkg;

    localparam int AXI_WORD_W = 32;

    // status readback layout; [7:0] is the write pointer, [15:12] reads 0
    localparam int STAT_FULL    = 8;
    localparam int STAT_VALID   = 9;
    localparam int STAT_OVF     = 10;
    localparam int STAT_UDR     = 11;
    localparam int STAT_CNT_LSB = 16;
    localparam int STAT_NW_LSB  = 24;

    // number of AXI words needed to carry a frame of 'width' bits
    function automatic int num_words(input int width);
        return (width + AXI_WORD_W - 1) / AXI_WORD_W;
    endfunction

endpackage

// File: rtl/single_frame_loader_if.sv
// Register-side bus of single_frame_loader.
// master: software/register file side (drives writes, commit, clear; reads frame and status)
// slave : the loader itself
//   frame_write           word written by software
//   frame_write_wrStrobe  level strobe, each rising edge is one word write
//   commit                each rising edge requests a staging -> frame_out transfer
//   clear                 synchronous staging/error clear
//   frame_out             committed frame
//   frame_valid           a frame has been committed since reset
//   status                readback word
interface single_frame_loader_if
    import pixel_buffer_pkg::*;
#(
    parameter int FRAME_WIDTH = 234
);
    logic [AXI_WORD_W-1:0]  frame_write;
    logic                   frame_write_wrStrobe;
    logic                   commit;
    logic                   clear;
    logic [FRAME_WIDTH-1:0] frame_out;
    logic                   frame_valid;
    logic [AXI_WORD_W-1:0]  status;

    modport master (
        output frame_write, frame_write_wrStrobe, commit, clear,
        input  frame_out, frame_valid, status
    );

    modport slave (
        input  frame_write, frame_write_wrStrobe, commit, clear,
        output frame_out, frame_valid, status
    );
endinterface

// File: rtl/single_frame_loader_rise_edge_detect.sv
// Single-bit rising-edge detector.
//   clk, resetn  clock and asynchronous active-low reset
//   in_sig       level input
//   pulse        high for the first cycle in_sig is seen high
// prev resets to 0, so an input already high when reset releases yields one pulse.
module rise_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic in_sig,
    output logic pulse
);
    logic prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) prev <= 1'b0;
        else         prev <= in_sig;
    end

    assign pulse = in_sig & ~prev;
endmodule

// File: rtl/single_frame_loader.sv
// single_frame_loader: software writes a frame as 32-bit words into a staging
// buffer; a commit edge copies the whole staged frame to frame_out atomically.
//   axi_clk     clock for all logic
//   axi_resetn  asynchronous active-low reset
//   bus         single_frame_loader_if.slave (writes, commit, clear, frame_out,
//               frame_valid, status)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// EMPTY    | wr_ptr == 0, no words staged since last commit/clear
// FILLING  | 0 < wr_ptr < NUM_WORDS, frame partly staged
// FULL     | wr_ptr == NUM_WORDS, commit accepted, further writes overflow
module single_frame_loader
    import pixel_buffer_pkg::*;
#(
    parameter int FRAME_WIDTH = 234
)(
    input logic               axi_clk,
    input logic               axi_resetn,
    single_frame_loader_if.slave bus
);
    localparam int         NUM_WORDS = num_words(FRAME_WIDTH);
    localparam int         LAST_BITS = FRAME_WIDTH - AXI_WORD_W * (NUM_WORDS - 1);
    localparam logic [7:0] NW8       = 8'(NUM_WORDS);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic                   wr_ev;
    logic                   cm_ev;
    logic [1:0]             state;

    logic [7:0]             wr_ptr,       wr_ptr_nxt;
    logic [FRAME_WIDTH-1:0] staging,      staging_nxt;
    logic [FRAME_WIDTH-1:0] frame_out_q,  frame_out_nxt;
    logic                   frame_valid_q, frame_valid_nxt;
    logic [7:0]             commit_count, commit_count_nxt;
    logic                   overflow,     overflow_nxt;
    logic                   underrun,     underrun_nxt;
    logic [AXI_WORD_W-1:0]  status_q,     status_nxt;

    rise_edge_detect u_wr_edge (
        .clk    (axi_clk),
        .resetn (axi_resetn),
        .in_sig (bus.frame_write_wrStrobe),
        .pulse  (wr_ev)
    );

    rise_edge_detect u_cm_edge (
        .clk    (axi_clk),
        .resetn (axi_resetn),
        .in_sig (bus.commit),
        .pulse  (cm_ev)
    );

    always_comb begin
        state = ST_FILLING;
        if (wr_ptr == 8'd0)     state = ST_EMPTY;
        else if (wr_ptr == NW8) state = ST_FULL;
    end

    // Write and commit are both judged against the pre-write pointer: a write
    // that completes the frame in the same cycle as a commit still leaves the
    // commit rejected, and a commit in FULL swallows a simultaneous write.
    always_comb begin
        wr_ptr_nxt       = wr_ptr;
        staging_nxt      = staging;
        frame_out_nxt    = frame_out_q;
        frame_valid_nxt  = frame_valid_q;
        commit_count_nxt = commit_count;
        overflow_nxt     = overflow;
        underrun_nxt     = underrun;

        if (bus.clear) begin
            wr_ptr_nxt   = 8'd0;
            staging_nxt  = '0;
            overflow_nxt = 1'b0;
            underrun_nxt = 1'b0;
        end else begin
            if (wr_ev) begin
                if (state == ST_FULL) begin
                    overflow_nxt = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_WORDS - 1; k++) begin
                        if (wr_ptr == 8'(k))
                            staging_nxt[AXI_WORD_W*k +: AXI_WORD_W] = bus.frame_write;
                    end
                    // last word only carries the frame's remaining bits
                    if (wr_ptr == 8'(NUM_WORDS - 1))
                        staging_nxt[FRAME_WIDTH-1 -: LAST_BITS] = bus.frame_write[LAST_BITS-1:0];
                    wr_ptr_nxt = wr_ptr + 8'd1;
                end
            end
            if (cm_ev) begin
                if (state == ST_FULL) begin
                    frame_out_nxt    = staging;
                    frame_valid_nxt  = 1'b1;
                    commit_count_nxt = commit_count + 8'd1;
                    wr_ptr_nxt       = 8'd0;
                end else begin
                    underrun_nxt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        status_nxt                        = '0;
        status_nxt[7:0]                   = wr_ptr_nxt;
        status_nxt[STAT_FULL]             = (wr_ptr_nxt == NW8);
        status_nxt[STAT_VALID]            = frame_valid_nxt;
        status_nxt[STAT_OVF]              = overflow_nxt;
        status_nxt[STAT_UDR]              = underrun_nxt;
        status_nxt[STAT_CNT_LSB +: 8]     = commit_count_nxt;
        status_nxt[STAT_NW_LSB +: 8]      = NW8;
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_ptr        <= 8'd0;
            staging       <= '0;
            frame_out_q   <= '0;
            frame_valid_q <= 1'b0;
            commit_count  <= 8'd0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
            status_q      <= '0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            staging       <= staging_nxt;
            frame_out_q   <= frame_out_nxt;
            frame_valid_q <= frame_valid_nxt;
            commit_count  <= commit_count_nxt;
            overflow      <= overflow_nxt;
            underrun      <= underrun_nxt;
            status_q      <= status_nxt;
        end
    end

    assign bus.frame_out   = frame_out_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.status      = status_q;
endmodule

// File: tb/tb_single_frame_loader.sv
// Testbench for single_frame_loader: directed scenarios plus a random phase,
// with a per-cycle scoreboard fed by a word-level reference model.
module tb_single_frame_loader;
    import pixel_buffer_pkg::*;

    localparam int FW = 234;
    localparam int NW = num_words(FW);

    logic axi_clk    = 1'b0;
    logic axi_resetn = 1'b0;
    always #5 axi_clk = ~axi_clk;

    single_frame_loader_if #(.FRAME_WIDTH(FW)) bus_if ();

    single_frame_loader #(.FRAME_WIDTH(FW)) dut (
        .axi_clk    (axi_clk),
        .axi_resetn (axi_resetn),
        .bus        (bus_if)
    );

    typedef struct {
        logic [FW-1:0] frame;
        logic          valid;
        logic [31:0]   status;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model: staged words, pointer, committed frame, counters
    logic [31:0]   m_stg [NW];
    int            m_ptr;
    logic [FW-1:0] m_out;
    bit            m_valid, m_ovf, m_udr, m_pw, m_pc;
    int            m_cnt;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {8'(NW), 8'(m_cnt), 4'h0, m_udr, m_ovf, m_valid, (m_ptr == NW), 8'(m_ptr)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NW; k++) m_stg[k] = '0;
        m_ptr = 0; m_out = '0; m_valid = 0; m_cnt = 0;
        m_ovf = 0; m_udr = 0; m_pw = 0; m_pc = 0;
    endtask

    task automatic model_step(input bit w, input bit c, input bit clr, input logic [31:0] d);
        bit we, ce, full0;
        logic [255:0] whole;
        we = w && !m_pw;
        ce = c && !m_pc;
        m_pw = w;
        m_pc = c;
        if (clr) begin
            m_ptr = 0;
            for (int k = 0; k < NW; k++) m_stg[k] = '0;
            m_ovf = 0;
            m_udr = 0;
        end else begin
            full0 = (m_ptr == NW);
            if (we) begin
                if (full0) m_ovf = 1;
                else begin
                    m_stg[m_ptr] = d;
                    m_ptr++;
                end
            end
            if (ce) begin
                if (full0) begin
                    whole = '0;
                    for (int k = 0; k < NW; k++) whole[32*k +: 32] = m_stg[k];
                    m_out   = whole[FW-1:0];
                    m_valid = 1;
                    m_cnt   = (m_cnt + 1) % 256;
                    m_ptr   = 0;
                end else begin
                    m_udr = 1;
                end
            end
        end
    endtask

    task automatic cyc(input bit w, input bit c, input bit clr, input logic [31:0] d);
        exp_t e;
        @(negedge axi_clk);
        bus_if.frame_write_wrStrobe = w;
        bus_if.commit               = c;
        bus_if.clear                = clr;
        bus_if.frame_write          = d;
        model_step(w, c, clr, d);
        e.frame  = m_out;
        e.valid  = m_valid;
        e.status = m_status();
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] d);
        cyc(1, 0, 0, d);
        cyc(0, 0, 0, d);
    endtask

    task automatic cm();
        cyc(0, 1, 0, 32'h0);
        cyc(0, 0, 0, 32'h0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_frame_out"}, 256'(bus_if.frame_out), 256'(0));
        chk({tag, "_frame_valid"}, 256'(bus_if.frame_valid), 256'(0));
        chk({tag, "_status"}, 256'(bus_if.status), 256'(0));
    endtask

    // monitor: one expected entry per driven cycle, checked just after the edge
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge axi_clk);
            #1;
            if (axi_resetn && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("sb_frame_out", 256'(bus_if.frame_out), 256'(mon_e.frame));
                chk("sb_frame_valid", 256'(bus_if.frame_valid), 256'(mon_e.valid));
                chk("sb_status", 256'(bus_if.status), 256'(mon_e.status));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [FW-1:0] exp1, exp3;
    logic [31:0]   w3 [NW];
    logic [255:0]  tmp;

    initial begin
        bus_if.frame_write          = '0;
        bus_if.frame_write_wrStrobe = 1'b0;
        bus_if.commit               = 1'b0;
        bus_if.clear                = 1'b0;
        model_reset();
        #1;
        reset_checks("reset");
        repeat (2) @(negedge axi_clk);
        axi_resetn = 1'b1;

        // 1: full frame, last word upper bits dropped
        for (int i = 1; i <= 7; i++) wr(32'(i));
        wr(32'hFFFF_FC08);
        cm();
        exp1 = {10'h008, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        chk("s1_frame_out", 256'(bus_if.frame_out), 256'(exp1));
        chk("s1_valid", 256'(bus_if.frame_valid), 256'(1));
        chk("s1_count", 256'(bus_if.status[23:16]), 256'(1));
        chk("s1_wr_ptr", 256'(bus_if.status[7:0]), 256'(0));
        chk("s1_num_words", 256'(bus_if.status[31:24]), 256'(8));

        // 2: held strobe is one write; short frame commit underruns
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 32'hA5A5_A5A5);
        cyc(0, 0, 0, 32'h0);
        chk("s2_wr_ptr_held", 256'(bus_if.status[7:0]), 256'(1));
        for (int i = 0; i < 6; i++) wr($urandom);
        cm();
        chk("s2_underrun", 256'(bus_if.status[STAT_UDR]), 256'(1));
        chk("s2_frame_kept", 256'(bus_if.frame_out), 256'(exp1));

        // 3: ninth word overflows and is not committed
        cyc(0, 0, 1, 32'h0);
        cyc(0, 0, 0, 32'h0);
        for (int i = 0; i < NW; i++) begin
            w3[i] = $urandom;
            wr(w3[i]);
        end
        wr(32'h0000_DEAD);
        chk("s3_overflow", 256'(bus_if.status[STAT_OVF]), 256'(1));
        chk("s3_wr_ptr", 256'(bus_if.status[7:0]), 256'(8));
        cm();
        tmp = '0;
        for (int i = 0; i < NW; i++) tmp[32*i +: 32] = w3[i];
        exp3 = tmp[FW-1:0];
        chk("s3_frame_out", 256'(bus_if.frame_out), 256'(exp3));
        chk("s3_count", 256'(bus_if.status[23:16]), 256'(2));

        // 4: clear wins over a same-cycle commit
        for (int i = 0; i < NW; i++) wr($urandom);
        cyc(0, 1, 1, 32'h0);
        cyc(0, 0, 0, 32'h0);
        chk("s4_wr_ptr", 256'(bus_if.status[7:0]), 256'(0));
        chk("s4_errors", 256'(bus_if.status[11:10]), 256'(0));
        chk("s4_count", 256'(bus_if.status[23:16]), 256'(2));
        chk("s4_frame_kept", 256'(bus_if.frame_out), 256'(exp3));

        // 5: completing write and commit together -> underrun, then commit accepted
        for (int i = 0; i < NW - 1; i++) wr($urandom);
        cyc(1, 1, 0, $urandom);
        cyc(0, 0, 0, 32'h0);
        chk("s5_full", 256'(bus_if.status[8:0]), 256'(9'h108));
        chk("s5_underrun", 256'(bus_if.status[STAT_UDR]), 256'(1));
        cm();
        chk("s5_count", 256'(bus_if.status[23:16]), 256'(3));

        // 6: reset mid-fill
        for (int i = 0; i < 4; i++) wr($urandom);
        @(negedge axi_clk);
        axi_resetn = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        reset_checks("s6_reset");
        repeat (3) @(negedge axi_clk);
        axi_resetn = 1'b1;
        for (int i = 0; i < NW; i++) wr($urandom);
        cm();
        chk("s6_valid", 256'(bus_if.frame_valid), 256'(1));
        chk("s6_count", 256'(bus_if.status[23:16]), 256'(1));

        // random phase
        for (int i = 0; i < 600; i++) begin
            cyc(bit'($urandom_range(0, 1)), ($urandom % 5) == 0, ($urandom % 40) == 0, $urandom);
        end
        cyc(0, 0, 0, 32'h0);
        @(negedge axi_clk);
        chk("queue_drained", 256'(exp_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
